// File: rtl/branch_sequencer_pkg.sv
// Shared types and constants for the branch sequencer: state encoding and
// the position of the C2 condition field inside the instruction register.
package branch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_T3,
    ST_T4,
    ST_T5,
    ST_T6,
    ST_FIN
  } state_t;

  localparam int unsigned C2_MSB = 20;
  localparam int unsigned C2_LSB = 19;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones, never wraps.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Control sequencer for conditional branch instructions (T3..T6 microsteps)
// with branch outcome reporting and taken/not-taken statistics.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             hold,
  input  logic             con_ff,
  output logic             gra,
  output logic             rout,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlow_out,
  output logic             pc_in,
  output logic [1:0]       con_ir_bits,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] not_taken_cnt
);

  state_t state, next_state;
  logic   con_s;
  logic   fin_step;

  // Only the C2 field is consumed; the rest of the IR belongs to the datapath.
  logic unused_ir;
  assign unused_ir = ^{ir[31:C2_MSB+1], ir[C2_LSB-1:0]};

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!hold) begin
      unique case (state)
        ST_IDLE: if (start) next_state = ST_T3;
        ST_T3:   next_state = ST_T4;
        ST_T4:   next_state = ST_T5;
        ST_T5:   next_state = ST_T6;
        ST_T6:   next_state = ST_FIN;
        ST_FIN:  next_state = ST_IDLE;
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // con_ff is sampled once, at the T5->T6 edge; taken is published on FIN entry.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      con_ir_bits <= 2'b00;
      con_s       <= 1'b0;
      taken       <= 1'b0;
    end else if (!hold) begin
      if (state == ST_IDLE && start) con_ir_bits <= ir[C2_MSB:C2_LSB];
      if (state == ST_T5)            con_s       <= con_ff;
      if (state == ST_T6)            taken       <= con_s;
    end
  end

  always_comb begin
    gra      = 1'b0;
    rout     = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    pc_in    = 1'b0;
    done     = 1'b0;
    busy     = (state != ST_IDLE);
    if (!hold) begin
      unique case (state)
        ST_T3:   begin gra = 1'b1; rout = 1'b1; con_in = 1'b1; end
        ST_T4:   begin pc_out = 1'b1; y_in = 1'b1; end
        ST_T5:   begin c_out = 1'b1; alu_add = 1'b1; z_in = 1'b1; end
        ST_T6:   begin zlow_out = con_s; pc_in = con_s; end
        ST_FIN:  done = 1'b1;
        default: ;
      endcase
    end
  end

  assign fin_step = done;

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (clr),
    .inc   (fin_step & taken),
    .count (taken_cnt)
  );

  sat_counter #(.W(CNT_W)) u_not_taken_cnt (
    .clk   (clk),
    .rst_n (clr),
    .inc   (fin_step & ~taken),
    .count (not_taken_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// branches checked against a transaction-level timeline model.
module tb_branch_sequencer;

  localparam int unsigned CW = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [31:0]   ir;
  logic          hold;
  logic          con_ff;
  logic          gra, rout, con_in, pc_out, y_in, c_out, alu_add, z_in, zlow_out, pc_in;
  logic [1:0]    con_ir_bits;
  logic          busy, done, taken;
  logic [CW-1:0] taken_cnt, not_taken_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model of architecturally visible history.
  logic        m_taken = 1'b0;
  logic [1:0]  m_bits  = 2'b00;
  int unsigned m_tc    = 0;
  int unsigned m_ntc   = 0;

  typedef struct {
    int unsigned ph;
    bit          held;
  } step_t;

  branch_sequencer #(.CNT_W(CW)) dut (
    .clk           (clk),
    .clr           (clr),
    .start         (start),
    .ir            (ir),
    .hold          (hold),
    .con_ff        (con_ff),
    .gra           (gra),
    .rout          (rout),
    .con_in        (con_in),
    .pc_out        (pc_out),
    .y_in          (y_in),
    .c_out         (c_out),
    .alu_add       (alu_add),
    .z_in          (z_in),
    .zlow_out      (zlow_out),
    .pc_in         (pc_in),
    .con_ir_bits   (con_ir_bits),
    .busy          (busy),
    .done          (done),
    .taken         (taken),
    .taken_cnt     (taken_cnt),
    .not_taken_cnt (not_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [9:0] e_strb, input logic e_busy,
                           input logic e_done, input logic e_taken, input logic [1:0] e_bits,
                           input int unsigned e_tc, input int unsigned e_ntc);
    check({tag, ".strobes"}, {22'd0, gra, rout, con_in, pc_out, y_in, c_out, alu_add, z_in,
                              zlow_out, pc_in}, {22'd0, e_strb});
    check({tag, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    check({tag, ".done"}, {31'd0, done}, {31'd0, e_done});
    check({tag, ".taken"}, {31'd0, taken}, {31'd0, e_taken});
    check({tag, ".con_ir_bits"}, {30'd0, con_ir_bits}, {30'd0, e_bits});
    check({tag, ".taken_cnt"}, {28'd0, taken_cnt}, e_tc);
    check({tag, ".not_taken_cnt"}, {28'd0, not_taken_cnt}, e_ntc);
  endtask

  function automatic logic [9:0] phase_strobes(input int unsigned ph, input bit held, input logic con);
    if (held) return 10'b0;
    case (ph)
      1: return 10'b1110000000;
      2: return 10'b0001100000;
      3: return 10'b0000011100;
      4: return con ? 10'b0000000011 : 10'b0;
      default: return 10'b0;
    endcase
  endfunction

  // One full branch; hold_ph 0 means no stall, otherwise stall phase hold_ph
  // (1=T3 .. 4=T6) for hold_n cycles. spurious re-pulses start during T4.
  task automatic run_branch(input string tag, input logic [1:0] c2, input logic con,
                            input int unsigned hold_ph, input int unsigned hold_n,
                            input bit spurious);
    step_t       q[$];
    logic [31:0] w;
    w = $urandom;
    w[20:19] = c2;
    ir = w;
    start = 1'b1;
    hold = 1'b0;
    con_ff = 1'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    for (int unsigned p = 1; p <= 5; p++) begin
      if (p == hold_ph) for (int unsigned k = 0; k < hold_n; k++) q.push_back('{p, 1'b1});
      q.push_back('{p, 1'b0});
    end
    foreach (q[i]) begin
      hold = q[i].held;
      con_ff = (q[i].ph == 3 && !q[i].held) ? con : 1'($urandom);
      w = $urandom;
      w[20:19] = ~c2;
      ir = w;
      start = spurious && q[i].ph == 2 && !q[i].held;
      #1;
      check_all($sformatf("%s.c%0d", tag, i), phase_strobes(q[i].ph, q[i].held, con), 1'b1,
                q[i].ph == 5 && !q[i].held, (q[i].ph == 5) ? con : m_taken, c2, m_tc, m_ntc);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    m_taken = con;
    m_bits = c2;
    if (con) m_tc = (m_tc == CMAX) ? CMAX : m_tc + 1;
    else     m_ntc = (m_ntc == CMAX) ? CMAX : m_ntc + 1;
    #1;
    check_all({tag, ".idle"}, 10'b0, 1'b0, 1'b0, m_taken, m_bits, m_tc, m_ntc);
  endtask

  initial begin
    clr = 1'b0;
    start = 1'b0;
    ir = '0;
    hold = 1'b0;
    con_ff = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 10'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);

    // Reset dropped in T5 abandons the branch asynchronously.
    clr = 1'b1;
    ir = 32'h0018_0000;
    start = 1'b1;
    con_ff = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    #1;
    check("midrst.t3_busy", {31'd0, busy}, 32'd1);
    check("midrst.t3_bits", {30'd0, con_ir_bits}, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #2;
    check("midrst.t5_cout", {31'd0, c_out}, 32'd1);
    clr = 1'b0;
    #1;
    check_all("midrst.async", 10'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    @(posedge clk); #1;
    check_all("midrst.held", 10'b0, 1'b0, 1'b0, 1'b0, 2'b00, 0, 0);
    clr = 1'b1;

    // First start after reset release is taken on the very next edge.
    run_branch("brzr_taken", 2'b00, 1'b1, 0, 0, 1'b0);
    run_branch("c01_not_taken", 2'b01, 1'b0, 0, 0, 1'b0);
    run_branch("hold_t4", 2'b10, 1'b1, 2, 3, 1'b0);
    run_branch("restart_t4", 2'b11, 1'b0, 0, 0, 1'b1);
    run_branch("hold_t5", 2'b01, 1'b1, 3, 2, 1'b0);

    for (int unsigned n = 0; n < 24; n++) begin
      run_branch($sformatf("rnd%0d", n), 2'($urandom), 1'($urandom),
                 $urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom));
    end

    for (int unsigned n = 0; n < 17; n++) begin
      run_branch($sformatf("sat%0d", n), 2'($urandom), 1'b1, 0, 0, 1'b0);
    end
    check("sat.final", {28'd0, taken_cnt}, CMAX);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
